// File: rtl/rotate_pkg.sv
// Shared encodings for the rotate arbiter: op codes, decoded op kinds,
// FSM state constants and the rotator-count helper.
package rotate_pkg;

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_LSL = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [2:0] {
    OPK_ROR  = 3'd0,
    OPK_ROL  = 3'd1,
    OPK_LSR  = 3'd2,
    OPK_LSL  = 3'd3,
    OPK_ASR  = 3'd4,
    OPK_PASS = 3'd5
  } op_kind_e;

  // Callers zero-extend their op field to 8 bits; any unlisted code is pass-through.
  function automatic op_kind_e decode_op(input logic [7:0] op);
    op_kind_e kind;
    case (op)
      {5'd0, OP_ROR}: kind = OPK_ROR;
      {5'd0, OP_ROL}: kind = OPK_ROL;
      {5'd0, OP_LSR}: kind = OPK_LSR;
      {5'd0, OP_LSL}: kind = OPK_LSL;
      {5'd0, OP_ASR}: kind = OPK_ASR;
      default:        kind = OPK_PASS;
    endcase
    return kind;
  endfunction

  // The rotator only turns right, so left-going ops use the complementary count.
  function automatic logic [2:0] rot_count(input op_kind_e kind, input logic [2:0] amt);
    logic [2:0] cnt;
    case (kind)
      OPK_ROR, OPK_LSR, OPK_ASR: cnt = amt;
      OPK_ROL, OPK_LSL:          cnt = 3'd0 - amt;
      default:                   cnt = 3'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/shift_mask_gen.sv
// Turns the raw right-rotated operand into the final shift result and
// produces the shifted-out carry bit.
module shift_mask_gen
  import rotate_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      amt,
  input  logic [7:0]      data,
  input  logic [7:0]      rot_out,
  output logic [7:0]      result,
  output logic            carry
);

  op_kind_e   kind;
  logic [7:0] keep_low;
  logic [7:0] keep_high;
  logic       amt_nz;

  // Mask the rotated value and pick the carry bit for the decoded op.
  always_comb begin
    kind      = decode_op(8'(op));
    keep_low  = 8'hFF >> amt;
    keep_high = 8'hFF << amt;
    amt_nz    = (amt != 3'd0);
    result    = rot_out;
    carry     = 1'b0;
    case (kind)
      OPK_LSR: begin
        result = rot_out & keep_low;
        carry  = amt_nz ? data[amt - 3'd1] : 1'b0;
      end
      OPK_ASR: begin
        result = (rot_out & keep_low) | ({8{data[7]}} & ~keep_low);
        carry  = amt_nz ? data[amt - 3'd1] : 1'b0;
      end
      OPK_LSL: begin
        result = rot_out & keep_high;
        carry  = amt_nz ? data[3'd0 - amt] : 1'b0;
      end
      OPK_ROR: begin
        result = rot_out;
        carry  = amt_nz ? rot_out[7] : 1'b0;
      end
      OPK_ROL: begin
        result = rot_out;
        carry  = amt_nz ? rot_out[0] : 1'b0;
      end
      default: begin
        result = rot_out;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Two-requester round-robin front end for a shared external right-rotator,
// sequencing issue, capture and completion through a four-state FSM.
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_hazard,
  input  logic            req_a,
  input  logic            req_b,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  input  logic [7:0]      data_a,
  input  logic [7:0]      data_b,
  input  logic [2:0]      amt_a,
  input  logic [2:0]      amt_b,
  output logic            gnt_a,
  output logic            gnt_b,
  output logic [7:0]      rot_in,
  output logic [2:0]      rot_R,
  input  logic [7:0]      rot_out,
  output logic [7:0]      result,
  output logic            carry,
  output logic            result_valid,
  output logic            result_id,
  output logic            busy
);

  logic [1:0]      state_q, state_d;
  logic            prio_b_q, prio_b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      amt_q, amt_d;
  logic            id_q, id_d;
  logic            gnt_a_q, gnt_a_d;
  logic            gnt_b_q, gnt_b_d;
  logic [7:0]      rot_in_q, rot_in_d;
  logic [2:0]      rot_r_q, rot_r_d;
  logic [7:0]      result_q, result_d;
  logic            carry_q, carry_d;
  logic            valid_q, valid_d;
  logic            result_id_q, result_id_d;

  logic            take_b;
  logic [OP_W-1:0] op_sel;
  logic [7:0]      data_sel;
  logic [2:0]      amt_sel;
  logic [7:0]      mask_result;
  logic            mask_carry;

  shift_mask_gen #(.OP_W(OP_W)) u_mask (
    .op      (op_q),
    .amt     (amt_q),
    .data    (data_q),
    .rot_out (rot_out),
    .result  (mask_result),
    .carry   (mask_carry)
  );

  // Arbitration and FSM next-state; prio_b_q set means B wins a tie.
  always_comb begin
    state_d     = state_q;
    prio_b_d    = prio_b_q;
    op_d        = op_q;
    data_d      = data_q;
    amt_d       = amt_q;
    id_d        = id_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rot_in_d    = rot_in_q;
    rot_r_d     = rot_r_q;
    result_d    = result_q;
    carry_d     = carry_q;
    valid_d     = 1'b0;
    result_id_d = result_id_q;
    take_b      = req_b & (~req_a | prio_b_q);
    op_sel      = take_b ? op_b : op_a;
    data_sel    = take_b ? data_b : data_a;
    amt_sel     = take_b ? amt_b : amt_a;
    case (state_q)
      ST_IDLE: begin
        if ((req_a | req_b) & ~data_hazard) begin
          state_d  = ST_ISSUE;
          gnt_a_d  = ~take_b;
          gnt_b_d  = take_b;
          prio_b_d = ~take_b;
          op_d     = op_sel;
          data_d   = data_sel;
          amt_d    = amt_sel;
          id_d     = take_b;
          rot_in_d = data_sel;
          rot_r_d  = rot_count(decode_op(8'(op_sel)), amt_sel);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!data_hazard) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_CAPTURE: begin
        if (!data_hazard) begin
          state_d  = ST_DONE;
          result_d = mask_result;
          carry_d  = mask_carry;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        valid_d     = 1'b1;
        result_id_d = id_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_b_q    <= 1'b0;
      op_q        <= '0;
      data_q      <= 8'h00;
      amt_q       <= 3'd0;
      id_q        <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rot_in_q    <= 8'h00;
      rot_r_q     <= 3'd0;
      result_q    <= 8'h00;
      carry_q     <= 1'b0;
      valid_q     <= 1'b0;
      result_id_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_b_q    <= prio_b_d;
      op_q        <= op_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      id_q        <= id_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rot_in_q    <= rot_in_d;
      rot_r_q     <= rot_r_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      valid_q     <= valid_d;
      result_id_q <= result_id_d;
    end
  end

  assign gnt_a        = gnt_a_q;
  assign gnt_b        = gnt_b_q;
  assign rot_in       = rot_in_q;
  assign rot_R        = rot_r_q;
  assign result       = result_q;
  assign carry        = carry_q;
  assign result_valid = valid_q;
  assign result_id    = result_id_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rotate_arbiter.sv
// Bench for rotate_arbiter: an external rotator model, a transaction-level
// reference compared every cycle, and directed scenarios with literal results.
module tb_rotate_arbiter;

  localparam int OP_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            data_hazard = 1'b0;
  logic            req_a = 1'b0, req_b = 1'b0;
  logic [OP_W-1:0] op_a = '0, op_b = '0;
  logic [7:0]      data_a = 8'h00, data_b = 8'h00;
  logic [2:0]      amt_a = 3'd0, amt_b = 3'd0;
  logic            gnt_a, gnt_b, carry, result_valid, result_id, busy;
  logic [7:0]      rot_in, result;
  logic [7:0]      rot_out = 8'h00;
  logic [2:0]      rot_R;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit compare_en = 1'b0;

  rotate_arbiter #(.OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .data_hazard(data_hazard),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .data_a(data_a), .data_b(data_b), .amt_a(amt_a), .amt_b(amt_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rot_in(rot_in), .rot_R(rot_R),
    .rot_out(rot_out), .result(result), .carry(carry),
    .result_valid(result_valid), .result_id(result_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain-arithmetic reference of the shift unit: returns {carry, result}.
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a);
    logic [15:0] w;
    logic [7:0]  r;
    logic        c;
    int          n;
    n = int'(a);
    w = {d, d};
    case (op)
      3'd0: begin r = 8'(w >> n);        c = r[7]; end
      3'd1: begin w = w << n; r = w[15:8]; c = r[0]; end
      3'd2: begin r = d >> n;            c = (n > 0) ? d[n-1] : 1'b0; end
      3'd3: begin r = d << n;            c = (n > 0) ? d[8-n] : 1'b0; end
      3'd4: begin r = 8'($signed(d) >>> n); c = (n > 0) ? d[n-1] : 1'b0; end
      default: begin r = d; c = 1'b0; end
    endcase
    if (n == 0) c = 1'b0;
    return {c, r};
  endfunction

  function automatic logic [2:0] ref_rot(input logic [2:0] op, input logic [2:0] a);
    int k;
    if (op == 3'd0 || op == 3'd2 || op == 3'd4) k = int'(a);
    else if (op == 3'd1 || op == 3'd3) k = (8 - int'(a)) % 8;
    else k = 0;
    return 3'(k);
  endfunction

  // External registered rotator, frozen by the hazard signal.
  always @(posedge clk) begin
    logic [15:0] w;
    w = {rot_in, rot_in} >> rot_R;
    if (!data_hazard) rot_out <= w[7:0];
  end

  // Reference: one outstanding transaction needing two hazard-free cycles, then a completion cycle.
  bit         m_active = 1'b0;
  bit         m_last_b = 1'b1;
  int         m_need = 0;
  logic [2:0] m_op = 3'd0;
  logic [7:0] m_data = 8'h00;
  logic [2:0] m_amt = 3'd0;
  bit         m_id = 1'b0;
  logic       e_gnt_a = 1'b0, e_gnt_b = 1'b0, e_valid = 1'b0, e_busy = 1'b0;
  logic [7:0] e_result = 8'h00, e_rot_in = 8'h00;
  logic       e_carry = 1'b0, e_id = 1'b0;
  logic [2:0] e_rot_r = 3'd0;

  always @(posedge clk) begin
    logic [8:0] rc;
    bit take_b;
    cyc = cyc + 1;
    e_gnt_a = 1'b0;
    e_gnt_b = 1'b0;
    e_valid = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_need = 0; m_last_b = 1'b1;
      e_result = 8'h00; e_carry = 1'b0; e_id = 1'b0; e_rot_in = 8'h00; e_rot_r = 3'd0;
    end else if (!m_active) begin
      if (!data_hazard && (req_a || req_b)) begin
        take_b = req_b && (!req_a || !m_last_b);
        m_last_b = take_b;
        m_id = take_b;
        m_op = take_b ? 3'(op_b) : 3'(op_a);
        m_data = take_b ? data_b : data_a;
        m_amt = take_b ? amt_b : amt_a;
        e_gnt_a = !take_b;
        e_gnt_b = take_b;
        e_rot_in = m_data;
        e_rot_r = ref_rot(m_op, m_amt);
        m_active = 1'b1;
        m_need = 2;
      end
    end else if (m_need > 0) begin
      if (!data_hazard) m_need = m_need - 1;
    end else begin
      rc = ref_op(m_op, m_data, m_amt);
      e_result = rc[7:0];
      e_carry = rc[8];
      e_id = m_id;
      e_valid = 1'b1;
      m_active = 1'b0;
    end
    e_busy = m_active;
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (compare_en) begin
      chk("gnt_a", {7'd0, gnt_a}, {7'd0, e_gnt_a});
      chk("gnt_b", {7'd0, gnt_b}, {7'd0, e_gnt_b});
      chk("result_valid", {7'd0, result_valid}, {7'd0, e_valid});
      chk("busy", {7'd0, busy}, {7'd0, e_busy});
      chk("rot_in", rot_in, e_rot_in);
      chk("rot_R", {5'd0, rot_R}, {5'd0, e_rot_r});
      if (!e_busy) begin
        chk("result", result, e_result);
        chk("carry", {7'd0, carry}, {7'd0, e_carry});
        chk("result_id", {7'd0, result_id}, {7'd0, e_id});
      end
    end
  end

  task automatic request(input bit use_b, input logic [2:0] op, input logic [7:0] d,
                         input logic [2:0] a, output int t_gnt);
    bit got;
    got = 1'b0;
    t_gnt = -1;
    @(negedge clk);
    if (use_b) begin req_b = 1'b1; op_b = op; data_b = d; amt_b = a; end
    else       begin req_a = 1'b1; op_a = op; data_a = d; amt_a = a; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (use_b ? gnt_b : gnt_a) begin
        got = 1'b1; t_gnt = cyc; req_a = 1'b0; req_b = 1'b0;
      end
    end
    if (!got) chk("gnt_timeout", 8'd0, 8'd1);
  endtask

  task automatic wait_valid(output int t_v);
    bit got;
    got = 1'b0;
    t_v = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (result_valid) begin got = 1'b1; t_v = cyc; end
    end
    if (!got) chk("valid_timeout", 8'd0, 8'd1);
  endtask

  task automatic pair(output int first, output int second);
    int n;
    n = 0; first = -1; second = -1;
    @(negedge clk);
    req_a = 1'b1; op_a = 3'd2; data_a = 8'hF0; amt_a = 3'd4;
    req_b = 1'b1; op_b = 3'd7; data_b = 8'h5A; amt_b = 3'd3;
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(negedge clk);
      if (gnt_a) begin if (n == 0) first = 0; else second = 0; n++; req_a = 1'b0; end
      if (gnt_b) begin if (n == 0) first = 1; else second = 1; n++; req_b = 1'b0; end
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t, tv, f, s, nv;
    @(negedge clk);
    compare_en = 1'b1;
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_result", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    request(1'b0, 3'd2, 8'hB5, 3'd3, t);
    chk("lsr_rot_R", {5'd0, rot_R}, 8'd3);
    wait_valid(tv);
    chk("lsr_latency", 8'(tv - t), 8'd3);
    chk("lsr_result", result, 8'h16);
    chk("lsr_carry", {7'd0, carry}, 8'd1);
    chk("lsr_id", {7'd0, result_id}, 8'd0);

    request(1'b1, 3'd4, 8'h96, 3'd2, t);
    chk("asr_rot_R", {5'd0, rot_R}, 8'd2);
    wait_valid(tv);
    chk("asr_result", result, 8'hE5);
    chk("asr_carry", {7'd0, carry}, 8'd1);
    chk("asr_id", {7'd0, result_id}, 8'd1);

    request(1'b0, 3'd1, 8'h81, 3'd1, t);
    chk("rol_rot_R", {5'd0, rot_R}, 8'd7);
    wait_valid(tv);
    chk("rol_result", result, 8'h03);
    chk("rol_carry", {7'd0, carry}, 8'd1);

    request(1'b0, 3'd3, 8'h81, 3'd1, t);
    chk("lsl_rot_R", {5'd0, rot_R}, 8'd7);
    wait_valid(tv);
    chk("lsl_result", result, 8'h02);
    chk("lsl_carry", {7'd0, carry}, 8'd1);

    do_reset();
    pair(f, s);
    chk("pair1_first", 8'(f), 8'd0);
    chk("pair1_second", 8'(s), 8'd1);
    pair(f, s);
    chk("pair2_first", 8'(f), 8'd0);
    chk("pair2_second", 8'(s), 8'd1);

    request(1'b0, 3'd0, 8'hC3, 3'd2, t);
    data_hazard = 1'b1;
    @(negedge clk);
    chk("stall_rot_in1", rot_in, 8'hC3);
    chk("stall_rot_R1", {5'd0, rot_R}, 8'd2);
    @(negedge clk);
    chk("stall_rot_in2", rot_in, 8'hC3);
    chk("stall_rot_R2", {5'd0, rot_R}, 8'd2);
    data_hazard = 1'b0;
    wait_valid(tv);
    chk("stall_latency", 8'(tv - t), 8'd5);
    chk("stall_result", result, 8'hF0);
    chk("stall_carry", {7'd0, carry}, 8'd1);

    request(1'b0, 3'd2, 8'hFF, 3'd1, t);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_result", result, 8'h00);
    chk("abort_rot_in", rot_in, 8'h00);
    chk("abort_rot_R", {5'd0, rot_R}, 8'd0);
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (result_valid) nv++;
    end
    chk("abort_no_valid", 8'(nv), 8'd0);
    request(1'b1, 3'd3, 8'h0F, 3'd4, t);
    chk("post_abort_rot_R", {5'd0, rot_R}, 8'd4);
    wait_valid(tv);
    chk("post_abort_result", result, 8'hF0);
    chk("post_abort_carry", {7'd0, carry}, 8'd0);
    chk("post_abort_id", {7'd0, result_id}, 8'd1);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (gnt_a) req_a = 1'b0;
      if (gnt_b) req_b = 1'b0;
      rst = ($urandom_range(0, 199) == 0);
      data_hazard = ($urandom_range(0, 4) == 0);
      if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1'b1; op_a = OP_W'($urandom_range(0, 7));
        data_a = 8'($urandom); amt_a = 3'($urandom);
      end
      if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1'b1; op_b = OP_W'($urandom_range(0, 7));
        data_b = 8'($urandom); amt_b = 3'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0; data_hazard = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rotate_arbiter.md
ROTATE_ARBITER -- requirements
Module: rotate_arbiter

Interface
REQ-001 SHALL have parameter OP_W, default 3, meaning width of the operation code.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-004 SHALL have port data_hazard, input, 1, meaning pipeline stall; the same signal also freezes the rotator register.
REQ-005 SHALL have ports req_a/req_b, input, 1 each, meaning the requester asks for a shift; held until granted.
REQ-006 SHALL have ports op_a/op_b, input, OP_W each, meaning operation: 000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR, others pass-through.
REQ-007 SHALL have ports data_a/data_b, input, 8 each, meaning operand.
REQ-008 SHALL have ports amt_a/amt_b, input, 3 each, meaning shift amount 0-7.
REQ-009 SHALL have ports gnt_a/gnt_b, output, 1 each, meaning a one-cycle pulse when that request's operands are latched.
REQ-010 SHALL have port rot_in, output, 8, meaning operand driven to the rotator.
REQ-011 SHALL have port rot_R, output, 3, meaning right-rotate count driven to the rotator.
REQ-012 SHALL have port rot_out, input, 8, meaning registered rotator result, valid one cycle after capture.
REQ-013 SHALL have port result, output, 8, meaning final masked result, held until the next completion.
REQ-014 SHALL have port carry, output, 1, meaning the last bit shifted or rotated out.
REQ-015 SHALL have port result_valid, output, 1, meaning a one-cycle completion pulse.
REQ-016 SHALL have port result_id, output, 1, meaning the owner of the result: 0 = A, 1 = B.
REQ-017 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, DONE.
REQ-019 IDLE: when req_a or req_b is high and data_hazard is low, SHALL grant, pulse the matching gnt, latch op/data/amt/id, and go to ISSUE; with data_hazard high it SHALL stay in IDLE with no grant.
REQ-020 Arbitration SHALL be round-robin: on a simultaneous request the requester not served last wins; after reset A has priority.
REQ-021 ISSUE: SHALL drive rot_in = latched data and rot_R per REQ-022; it SHALL advance to CAPTURE only on a cycle with data_hazard low, otherwise it SHALL hold and keep rot_in/rot_R stable.
REQ-022 rot_R SHALL be amt for ROR/LSR/ASR, (8-amt) mod 8 for ROL/LSL, and 0 for pass-through.
REQ-023 CAPTURE: on a cycle with data_hazard low, SHALL register the masked result and carry, then go to DONE; with data_hazard high it SHALL hold.
REQ-024 Masking SHALL be:
  - LSR clears the top amt bits.
  - LSL clears the low amt bits.
  - ASR fills the top amt bits with data[7].
  - ROR, ROL and pass-through are unmasked.
REQ-025 Carry SHALL be:
  - LSR/ASR: data[amt-1].
  - LSL: data[8-amt].
  - ROR: result[7].
  - ROL: result[0].
  - amt=0 or pass-through: carry = 0.
REQ-026 With amt=0 every op SHALL return data unchanged.
REQ-027 DONE: SHALL pulse result_valid for exactly one cycle with result_id, then return to IDLE unconditionally.
REQ-028 Latency with no stall SHALL be gnt at cycle T and result_valid at T+3; each stalled cycle SHALL add one cycle.
REQ-029 A new grant SHALL NOT occur before the cycle after DONE, so throughput is at most one op per 4 cycles.
REQ-030 Requests arriving while busy SHALL NOT be lost and SHALL be served in arbitration order once the FSM is back in IDLE.

Reset
REQ-031 On rst high the FSM SHALL enter IDLE and the following outputs SHALL be 0: gnt_a, gnt_b, result_valid, busy, result, carry, result_id, rot_in, rot_R.
REQ-032 Reset SHALL set the round-robin pointer to favor A.
REQ-033 Reset mid-operation SHALL abort the operation with no result_valid; reset SHALL take priority over data_hazard.

Structure
REQ-034 Op encodings and FSM state encodings SHALL live in a shared package, rotate_pkg.
REQ-035 Mask and carry generation SHALL be one combinational sub-module, shift_mask_gen, with inputs op, amt, data, rot_out and outputs result, carry.

Verification
REQ-036 Directed scenarios:
  - A LSR data 0xB5 amt 3 -> rot_R=3; result 0x16, carry 1, id 0, result_valid 3 cycles after gnt_a.
  - B ASR data 0x96 amt 2 -> rot_R=2; result 0xE5, carry 1, id 1.
  - A ROL 0x81 amt 1 -> rot_R=7, result 0x03, carry 1.
  - A LSL 0x81 amt 1 -> rot_R=7, result 0x02, carry 1.
  - req_a and req_b asserted together after reset and held -> A served first, then B; a second simultaneous pair -> A again.
  - data_hazard high 2 cycles during ISSUE -> rot_in/rot_R held; result_valid at T+5 with the correct value.
  - rst pulsed in CAPTURE -> no result_valid; outputs 0; next request served normally.
